// File: rtl/uart_pkg.sv
// uart_pkg: shared ASCII constants, message length and reporter FSM state type
package uart_pkg;
  localparam int MSG_LEN = 14;
  localparam logic [7:0] ASC_W     = 8'h57;
  localparam logic [7:0] ASC_S     = 8'h53;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_0     = 8'h30;
  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;
endpackage

// File: rtl/bin2ascii_2d.sv
// bin2ascii_2d: 7-bit value to two ASCII digits saturating at 99 (val in; tens, ones out)
module bin2ascii_2d
  import uart_pkg::*;
(
  input  logic [6:0] val,
  output logic [7:0] tens,
  output logic [7:0] ones
);
  logic [6:0] sat;
  always_comb begin
    sat  = val > 7'd99 ? 7'd99 : val;
    tens = ASC_0 + {1'b0, sat / 7'd10};
    ones = ASC_0 + {1'b0, sat % 7'd10};
  end
endmodule

// File: rtl/uart_time_reporter.sv
// uart_time_reporter: snapshot time on req/periodic tick, push 14-byte ASCII line to TX FIFO (clk, rst, req, watch_mode, hour, min, sec, csec, tx_full in; tx_push, tx_push_data, busy, done out)
module uart_time_reporter
  import uart_pkg::*;
#(
  parameter int PERIOD_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       watch_mode,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] csec,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_push_data,
  output logic       busy,
  output logic       done
);
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic       push_n, done_n, tick;
  logic [7:0] data_n;
  logic [7:0] h1, h0, m1, m0, s1, s0, c1, c0;
  logic [7:0] msg    [MSG_LEN];
  logic [7:0] msg_in [MSG_LEN];
  bin2ascii_2d u_hour (.val({2'b0, hour}), .tens(h1), .ones(h0));
  bin2ascii_2d u_min  (.val({1'b0, min}),  .tens(m1), .ones(m0));
  bin2ascii_2d u_sec  (.val({1'b0, sec}),  .tens(s1), .ones(s0));
  bin2ascii_2d u_csec (.val(csec),         .tens(c1), .ones(c0));
  always_comb
    msg_in = '{watch_mode ? ASC_W : ASC_S, h1, h0, ASC_COLON, m1, m0, ASC_COLON,
               s1, s0, ASC_DOT, c1, c0, ASC_CR, ASC_LF};
  assign busy = state != IDLE;
  if (PERIOD_CYCLES > 0) begin : g_per
    localparam int CW = PERIOD_CYCLES > 1 ? $clog2(PERIOD_CYCLES) : 1;
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(PERIOD_CYCLES - 1);
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else     cnt <= tick ? '0 : cnt + 1'b1;
  end else begin : g_no_per
    assign tick = 1'b0;
  end
  // idx points at the next byte to register; CAPTURE already registers byte 0
  // from the live conversion so the first push lands one cycle after CAPTURE.
  // idx == MSG_LEN means the last byte is on the port this cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    push_n  = 1'b0;
    data_n  = tx_push_data;
    done_n  = 1'b0;
    case (state)
      IDLE:    state_n = (req || tick) ? CAPTURE : IDLE;
      CAPTURE: begin
        state_n = SEND;
        push_n  = !tx_full;
        idx_n   = tx_full ? 4'd0 : 4'd1;
        data_n  = tx_full ? tx_push_data : msg_in[0];
      end
      SEND:
        if (idx == 4'(MSG_LEN)) begin
          state_n = IDLE;
          idx_n   = 4'd0;
          done_n  = 1'b1;
        end else if (!tx_full) begin
          push_n = 1'b1;
          data_n = msg[idx];
          idx_n  = idx + 4'd1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      idx          <= 4'd0;
      tx_push      <= 1'b0;
      tx_push_data <= 8'h00;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      tx_push      <= push_n;
      tx_push_data <= data_n;
      done         <= done_n;
    end
  always_ff @(posedge clk)
    if (state == CAPTURE) msg <= msg_in;
endmodule

// File: tb/tb_uart_time_reporter.sv
// tb_uart_time_reporter: scoreboard bench for uart_time_reporter (bytes, timing, stall, drop, saturation, reset, periodic)
module tb_uart_time_reporter;
  logic       clk = 0, rst = 1, req = 0, req_p = 0, watch_mode = 0, tx_full = 0;
  logic [4:0] hour = 0;
  logic [5:0] min = 0, sec = 0;
  logic [6:0] csec = 0;
  logic       tx_push, busy, done, tx_push_p, busy_p, done_p;
  logic [7:0] tx_push_data, tx_push_data_p;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int n_push = 0, n_done = 0, done_cyc = 0, n_push_p = 0, n_done_p = 0, done_cyc_p = 0;
  int push_cyc[$];
  logic [7:0] exp_q[$];
  int x, y, d, d1, d2, d3, p0, p1, n0, q;
  uart_time_reporter dut (
    .clk(clk), .rst(rst), .req(req), .watch_mode(watch_mode), .hour(hour), .min(min),
    .sec(sec), .csec(csec), .tx_full(tx_full), .tx_push(tx_push),
    .tx_push_data(tx_push_data), .busy(busy), .done(done));
  uart_time_reporter #(.PERIOD_CYCLES(100)) dut_p (
    .clk(clk), .rst(rst), .req(req_p), .watch_mode(watch_mode), .hour(hour), .min(min),
    .sec(sec), .csec(csec), .tx_full(1'b0), .tx_push(tx_push_p),
    .tx_push_data(tx_push_data_p), .busy(busy_p), .done(done_p));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask
  always @(negedge clk) begin
    if (tx_push) begin
      n_push++;
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_push", int'(tx_push), 0);
      else chk("byte", int'(tx_push_data), int'(exp_q.pop_front()));
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (tx_push_p) n_push_p++;
    if (done_p) begin n_done_p++; done_cyc_p = cyc; end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void push2(input int v);
    v = v > 99 ? 99 : v;
    exp_q.push_back(8'(48 + v / 10));
    exp_q.push_back(8'(48 + v % 10));
  endfunction
  task automatic send_req(input bit w, input int h, m, s, c, output int at);
    watch_mode = w; hour = 5'(h); min = 6'(m); sec = 6'(s); csec = 7'(c);
    exp_q.push_back(w ? 8'h57 : 8'h53);
    push2(h); exp_q.push_back(8'h3A); push2(m); exp_q.push_back(8'h3A);
    push2(s); exp_q.push_back(8'h2E); push2(c);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    req = 1; at = cyc;
    tick();
    req = 0;
  endtask
  task automatic wait_done(input int start, output int at);
    for (int i = 0; i < 100 && n_done == start; i++) tick();
    chk("done_seen", n_done, start + 1);
    at = done_cyc;
  endtask
  task automatic wait_done_p(input int start, output int at);
    for (int i = 0; i < 300 && n_done_p == start; i++) tick();
    chk("per_done_seen", n_done_p, start + 1);
    at = done_cyc_p;
  endtask
  initial begin
    tick(); tick();
    chk("rst_push", tx_push, 0); chk("rst_data", tx_push_data, 0);
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    rst = 0;
    tick();
    n0 = n_done; p0 = n_push;
    send_req(1, 12, 34, 56, 78, x);
    wait_done(n0, d);
    chk("w_first_push", push_cyc[p0], x + 2);
    chk("w_done_cyc", d, x + 16);
    chk("w_count", n_push - p0, 14);
    chk("w_busy_after", busy, 0);
    n0 = n_done; p0 = n_push;
    send_req(0, 0, 0, 0, 0, x);
    repeat (4) tick();
    watch_mode = 1; hour = 23; min = 59; sec = 59; csec = 99;
    wait_done(n0, d);
    chk("snap_count", n_push - p0, 14);
    chk("snap_done_cyc", d, x + 16);
    n0 = n_done; p0 = n_push;
    send_req(1, 1, 2, 3, 4, x);
    repeat (3) tick();
    tx_full = 1;
    repeat (5) tick();
    tx_full = 0;
    tick();
    chk("stall_pushes", n_push - p0, 3);
    wait_done(n0, d);
    chk("stall_done_cyc", d, x + 21);
    chk("stall_count", n_push - p0, 14);
    p0 = n_push;
    send_req(0, 9, 8, 7, 6, x);
    repeat (4) tick();
    req = 1;
    tick();
    req = 0;
    for (int i = 0; i < 40 && cyc < x + 16; i++) tick();
    chk("drop_done_now", done, 1);
    chk("drop_busy_now", busy, 0);
    chk("drop_count", n_push - p0, 14);
    p1 = n_push;
    send_req(1, 5, 6, 7, 8, y);
    n0 = n_done;
    wait_done(n0, d);
    chk("redo_first_push", push_cyc[p1], y + 2);
    chk("redo_done_cyc", d, y + 16);
    chk("redo_count", n_push - p1, 14);
    n0 = n_done; p0 = n_push;
    send_req(1, 31, 59, 63, 127, x);
    wait_done(n0, d);
    chk("sat_count", n_push - p0, 14);
    p0 = n_push;
    send_req(0, 10, 20, 30, 40, x);
    for (int i = 0; i < 40 && n_push - p0 < 6; i++) tick();
    chk("pre_rst_pushes", n_push - p0, 6);
    rst = 1;
    exp_q.delete();
    #1;
    chk("mid_rst_push", tx_push, 0); chk("mid_rst_data", tx_push_data, 0);
    chk("mid_rst_busy", busy, 0);    chk("mid_rst_done", done, 0);
    tick(); tick();
    rst = 0;
    p1 = n_push;
    repeat (20) tick();
    chk("post_rst_pushes", n_push - p1, 0);
    chk("post_rst_busy", busy, 0);
    wait_done_p(n_done_p, d1);
    q = n_push_p;
    for (int i = 0; i < 200 && cyc < d1 + 84; i++) tick();
    req_p = 1;
    tick();
    req_p = 0;
    wait_done_p(n_done_p, d2);
    chk("per_interval1", d2 - d1, 100);
    chk("per_count1", n_push_p - q, 14);
    q = n_push_p;
    wait_done_p(n_done_p, d3);
    chk("per_interval2", d3 - d2, 100);
    chk("per_count2", n_push_p - q, 14);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
